// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: FSM encoding and default sizing.
// INTC_ROUND_ROBIN_EN (optional) switches arbitration from fixed priority to round robin.
package intc_pkg;

    localparam int NUM_SRC_DEF = 8;
    localparam int VEC_W_DEF   = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

endpackage

// File: rtl/intc_if.sv
// Request/acknowledge handshake between the interrupt controller and the CPU control unit.
interface intc_if
    import intc_pkg::*;
#(
    parameter int VEC_W = VEC_W_DEF
);
    logic             int_req;
    logic [VEC_W-1:0] int_vector;
    logic             int_ack;
    logic             int_done;
    logic             in_service;

    modport master (
        output int_req,
        output int_vector,
        output in_service,
        input  int_ack,
        input  int_done
    );

    modport slave (
        input  int_req,
        input  int_vector,
        input  in_service,
        output int_ack,
        output int_done
    );
endinterface

// File: rtl/intc_prio_enc.sv
// Combinational arbiter: first set bit of eligible, searching upward from base and wrapping.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int VEC_W   = VEC_W_DEF
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [VEC_W-1:0]   base,
    output logic               found,
    output logic [VEC_W-1:0]   idx
);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(base) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (!found && eligible[j]) begin
                found = 1'b1;
                idx   = VEC_W'(j);
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Multi-source interrupt controller: sync + edge detect, pending/mask/GIE, one-at-a-time handshake.
// Define INTC_ROUND_ROBIN_EN to rotate arbitration priority past the last served source.
module int_controller
    import intc_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int VEC_W   = VEC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_din,
    input  logic               gie_set,
    input  logic               gie_clr,
    intc_if.master             cpu,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic               gie
);

    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d, mask_q;
    logic [NUM_SRC-1:0] rise, eligible, clr_vec;
    logic [1:0]         state_q, state_d;
    logic               req_q, req_d, svc_q, svc_d, gie_q, gie_d;
    logic [VEC_W-1:0]   vec_q, vec_d, base, win_idx;
    logic               win_found, take;

    // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~prev_q;
    assign eligible = gie_q ? (pending_q & ~mask_q) : '0;
    assign take     = (state_q == ST_REQ) && cpu.int_ack;
    assign clr_vec  = take ? (NUM_SRC'(1) << vec_q) : '0;
    // A fresh edge on the source being acknowledged must survive the clear.
    assign pending_d = (pending_q & ~clr_vec) | rise;

`ifdef INTC_ROUND_ROBIN_EN
    logic [VEC_W-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    last_q <= VEC_W'(NUM_SRC - 1);
        else if (take) last_q <= vec_q;
    end

    assign base = (last_q == VEC_W'(NUM_SRC - 1)) ? '0 : last_q + 1'b1;
`else
    assign base = '0;
`endif

    intc_prio_enc #(.NUM_SRC(NUM_SRC), .VEC_W(VEC_W)) u_prio (
        .eligible (eligible),
        .base     (base),
        .found    (win_found),
        .idx      (win_idx)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        svc_d   = svc_q;
        vec_d   = vec_q;
        gie_d   = gie_q;
        if (state_q != ST_SERVICE) begin
            if (gie_clr)      gie_d = 1'b0;
            else if (gie_set) gie_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: if (win_found) begin
                vec_d   = win_idx;
                req_d   = 1'b1;
                state_d = ST_REQ;
            end
            ST_REQ: if (cpu.int_ack) begin
                req_d   = 1'b0;
                svc_d   = 1'b1;
                gie_d   = 1'b0;
                state_d = ST_SERVICE;
            end
            ST_SERVICE: if (cpu.int_done) begin
                svc_d   = 1'b0;
                gie_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                svc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            svc_q     <= 1'b0;
            vec_q     <= '0;
            gie_q     <= 1'b0;
            pending_q <= '0;
            mask_q    <= '1;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            svc_q     <= svc_d;
            vec_q     <= vec_d;
            gie_q     <= gie_d;
            pending_q <= pending_d;
            if (mask_wr) mask_q <= mask_din;
        end
    end

    assign cpu.int_req    = req_q;
    assign cpu.int_vector = vec_q;
    assign cpu.in_service = svc_q;
    assign pending        = pending_q;
    assign mask           = mask_q;
    assign gie            = gie_q;

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed handshake scenarios, then random traffic vs a model.
module tb_int_controller;
    import intc_pkg::*;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq = '0;
    logic         mask_wr = 1'b0;
    logic [N-1:0] mask_din = '0;
    logic         gie_set = 1'b0;
    logic         gie_clr = 1'b0;
    logic [N-1:0] pending, mask;
    logic         gie;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    intc_if #(.VEC_W(W)) bus ();

    int_controller #(.NUM_SRC(N), .VEC_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq      (irq),
        .mask_wr  (mask_wr),
        .mask_din (mask_din),
        .gie_set  (gie_set),
        .gie_clr  (gie_clr),
        .cpu      (bus.master),
        .pending  (pending),
        .mask     (mask),
        .gie      (gie)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum logic [1:0] {M_IDLE, M_OFFER, M_BUSY} mphase_t;

    typedef struct packed {
        logic [2:0][N-1:0] smp;   // irq seen at the last three edges, [0] most recent
        logic [N-1:0]      pend;
        logic [N-1:0]      msk;
        logic              gie;
        mphase_t           phase;
        logic [W-1:0]      vec;
        logic [W-1:0]      last;
    } mstate_t;

    mstate_t m;

    function automatic logic [W-1:0] pick(input logic [N-1:0] elig, input int base);
        for (int k = 0; k < N; k++) begin
            if (elig[(base + k) % N]) return W'((base + k) % N);
        end
        return '0;
    endfunction

    function automatic mstate_t model_reset();
        mstate_t r;
        r.smp   = '0;
        r.pend  = '0;
        r.msk   = '1;
        r.gie   = 1'b0;
        r.phase = M_IDLE;
        r.vec   = '0;
        r.last  = W'(N - 1);
        return r;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic [N-1:0] irq_v,
                                           input logic mwr, input logic [N-1:0] mdin,
                                           input logic gs, input logic gc,
                                           input logic ack, input logic done);
        mstate_t      n;
        logic [N-1:0] edges;
        logic [N-1:0] elig;
        int           base;
        n     = s;
        edges = s.smp[1] & ~s.smp[2];
        n.smp = {s.smp[1], s.smp[0], irq_v};
        if (mwr) n.msk = mdin;
        if (s.phase != M_BUSY) begin
            if (gc)      n.gie = 1'b0;
            else if (gs) n.gie = 1'b1;
        end
`ifdef INTC_ROUND_ROBIN_EN
        base = (int'(s.last) + 1) % N;
`else
        base = 0;
`endif
        case (s.phase)
            M_IDLE: begin
                elig = s.gie ? (s.pend & ~s.msk) : '0;
                if (elig != '0) begin
                    n.vec   = pick(elig, base);
                    n.phase = M_OFFER;
                end
            end
            M_OFFER: if (ack) begin
                n.pend[s.vec] = 1'b0;
                n.gie         = 1'b0;
                n.last        = s.vec;
                n.phase       = M_BUSY;
            end
            default: if (done) begin
                n.gie   = 1'b1;
                n.phase = M_IDLE;
            end
        endcase
        n.pend = n.pend | edges;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, irq, mask_wr, mask_din, gie_set, gie_clr,
                                    bus.int_ack, bus.int_done);
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_int_req",    32'(bus.int_req),    32'(m.phase == M_OFFER));
            check("m_in_service", 32'(bus.in_service), 32'(m.phase == M_BUSY));
            check("m_int_vector", 32'(bus.int_vector), 32'(m.vec));
            check("m_pending",    32'(pending),        32'(m.pend));
            check("m_mask",       32'(mask),           32'(m.msk));
            check("m_gie",        32'(gie),            32'(m.gie));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic enable_all();
        mask_wr  = 1'b1;
        mask_din = '0;
        gie_set  = 1'b1;
        step(1);
        mask_wr  = 1'b0;
        gie_set  = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.int_ack = 1'b1;
        step(1);
        bus.int_ack = 1'b0;
    endtask

    task automatic done_pulse();
        bus.int_done = 1'b1;
        step(1);
        bus.int_done = 1'b0;
    endtask

    initial begin
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b0;
        cmp_en = 1'b1;
        #12;
        check("rst_int_req", 32'(bus.int_req), 32'h0);
        check("rst_pending", 32'(pending),     32'h00);
        check("rst_mask",    32'(mask),        32'hff);
        check("rst_gie",     32'(gie),         32'h0);
        rst_n = 1'b1;
        step(1);
        enable_all();
        check("en_mask", 32'(mask), 32'h00);
        check("en_gie",  32'(gie),  32'h1);

        // Edge to pending is three clocks; request follows one clock later.
        irq = 8'h08;
        step(2);
        check("lat_pend_early", 32'(pending), 32'h00);
        irq = 8'h00;
        step(1);
        check("lat_pend_set", 32'(pending),     32'h08);
        check("lat_req_early", 32'(bus.int_req), 32'h0);
        step(1);
        check("lat_req",  32'(bus.int_req),    32'h1);
        check("lat_vec",  32'(bus.int_vector), 32'h3);
        ack_pulse();
        check("ack_pend", 32'(pending),        32'h00);
        check("ack_gie",  32'(gie),            32'h0);
        check("ack_svc",  32'(bus.in_service), 32'h1);

        // Nesting block: new source pends, GIE writes ignored while in service.
        irq = 8'h02;
        gie_set = 1'b1;
        step(1);
        irq = 8'h00;
        gie_set = 1'b0;
        step(3);
        check("nest_pend", 32'(pending),     32'h02);
        check("nest_req",  32'(bus.int_req), 32'h0);
        check("nest_gie",  32'(gie),         32'h0);
        done_pulse();
        check("done_gie", 32'(gie),            32'h1);
        check("done_svc", 32'(bus.in_service), 32'h0);
        check("done_req", 32'(bus.int_req),    32'h0);
        step(1);
        check("nest_vec", 32'(bus.int_vector), 32'h1);
        ack_pulse();
        done_pulse();

        // Priority: 2 and 5 together.
        irq = 8'h24;
        step(2);
        irq = 8'h00;
        step(2);
        check("prio_first", 32'(bus.int_vector), 32'h2);
        ack_pulse();
        done_pulse();
        step(1);
        check("prio_second_req", 32'(bus.int_req),    32'h1);
        check("prio_second",     32'(bus.int_vector), 32'h5);
        ack_pulse();
        done_pulse();

        // Masking.
        mask_wr  = 1'b1;
        mask_din = 8'h10;
        step(1);
        mask_wr = 1'b0;
        irq = 8'h10;
        step(2);
        irq = 8'h00;
        step(3);
        check("mask_pend", 32'(pending),     32'h10);
        check("mask_req",  32'(bus.int_req), 32'h0);
        mask_wr  = 1'b1;
        mask_din = 8'h00;
        step(1);
        mask_wr = 1'b0;
        step(1);
        check("unmask_req", 32'(bus.int_req),    32'h1);
        check("unmask_vec", 32'(bus.int_vector), 32'h4);
        ack_pulse();
        done_pulse();

        // Collision: new edge on source 3 lands in its own ack cycle.
        irq = 8'h08;
        step(2);
        irq = 8'h00;
        step(2);
        check("coll_vec", 32'(bus.int_vector), 32'h3);
        irq = 8'h08;
        step(2);
        bus.int_ack = 1'b1;
        step(1);
        bus.int_ack = 1'b0;
        irq = 8'h00;
        check("coll_pend", 32'(pending),        32'h08);
        check("coll_svc",  32'(bus.in_service), 32'h1);
        done_pulse();
        step(1);
        check("coll_rereq", 32'(bus.int_req),    32'h1);
        check("coll_revec", 32'(bus.int_vector), 32'h3);

        // Asynchronous reset mid-handshake, away from any clock edge.
        rst_n = 1'b0;
        #1;
        check("arst_req",  32'(bus.int_req), 32'h0);
        check("arst_pend", 32'(pending),     32'h00);
        check("arst_gie",  32'(gie),         32'h0);
        check("arst_mask", 32'(mask),        32'hff);
        #1;
        rst_n = 1'b1;
        step(1);
        enable_all();

        // Random traffic, including out-of-state ack/done and GIE/mask churn.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) irq = irq ^ (N'(1) << $urandom_range(0, N - 1));
            mask_wr      = ($urandom_range(0, 19) == 0);
            mask_din     = N'($urandom & $urandom & $urandom);
            gie_set      = ($urandom_range(0, 3) == 0);
            gie_clr      = ($urandom_range(0, 15) == 0);
            bus.int_ack  = ($urandom_range(0, 2) == 0);
            bus.int_done = ($urandom_range(0, 3) == 0);
            step(1);
        end
        irq = '0;
        mask_wr = 1'b0;
        gie_set = 1'b0;
        gie_clr = 1'b0;
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b0;
        step(2);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
Multi-source interrupt controller feeding the CPU control unit's single io_interrupt input.
Synchronises and edge-detects NUM_SRC external request lines and latches them as pending bits. Arbitrates the unmasked pending bits and presents one vector with a request/acknowledge handshake. Holds off further interrupts until the handler signals completion (rit).
Also owns the global interrupt enable (GIE) and the per-source mask register.

Parameters:
NUM_SRC, 8, number of interrupt sources (2..16)
VEC_W, 4, vector width; 2**VEC_W >= NUM_SRC

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
irq  input  NUM_SRC  raw asynchronous source lines, rising-edge triggered
mask_wr  input  1  load mask register from mask_din
mask_din  input  NUM_SRC  new mask; 1 = source masked
gie_set  input  1  set global enable (from cmp_unmask_int)
gie_clr  input  1  clear global enable (from cmp_mask_int)
int_req  output  1  interrupt request to control unit (drives io_interrupt)
int_vector  output  VEC_W  index of the granted source; valid while int_req=1
int_ack  input  1  control unit has taken the vector (io_push_int_addr)
int_done  input  1  handler return (rit executed)
in_service  output  1  handler currently running
pending  output  NUM_SRC  latched pending bits, status read
mask  output  NUM_SRC  current mask register
gie  output  1  current global enable

Behaviour:
- Single clock domain: clk. rst_n is asynchronous and active-low and clears everything immediately, including mid-handshake.
- Reset values:
  - int_req=0, int_vector=0, in_service=0, gie=0.
  - pending=0, mask=all ones.
  - synchroniser and edge flops=0.
  - state=IDLE.
- Input conditioning:
  - irq passes through a 2-flop synchroniser, then a previous-value flop.
  - A rising edge of the synchronised value sets pending[i].
  - Latency from irq rise to pending bit set is 3 clk.
  - If the same source's pending bit is cleared by ack in the same cycle as a new edge, the set wins.
- Eligible set: pending & ~mask, considered only when gie=1.
- GIE writes: gie_clr takes priority over gie_set when both are asserted. Both are ignored while in SERVICE.
- mask_wr: the mask updates on the next edge and is legal in any state.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If the eligible set is non-zero, register the winner into int_vector, set int_req=1, go to REQ.
  - Request appears 1 clk after the pending bit.
- REQ:
  - int_vector and int_req are held stable.
  - The grant is committed: mask or gie changes do not retract it.
  - On int_ack: clear pending[int_vector], gie<=0, int_req<=0, in_service<=1, go to SERVICE.
- SERVICE:
  - New edges still accumulate in pending.
  - On int_done: gie<=1, in_service<=0, go to IDLE.
  - Arbitration for the next request happens the following cycle.
- Out-of-state inputs: int_ack outside REQ and int_done outside SERVICE are ignored.
- Arbitration without the optional feature is fixed priority: the lowest index wins.
- int_vector is zero-extended to VEC_W.

Optional Feature:
INTC_ROUND_ROBIN_EN
- Defined:
  - A last_served register (reset NUM_SRC-1) is updated on int_ack.
  - The search for the next winner starts at (last_served+1) mod NUM_SRC and wraps.
- Undefined: fixed lowest-index priority and no last_served register.
- Handshake timing is identical in both builds.

Decomposition:
- Package intc_pkg holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2)
  - default NUM_SRC and VEC_W constants
- Sub-module intc_prio_enc is combinational and takes eligible bits plus a rotation base.
  - Outputs: found flag and index.
  - Without the round-robin feature the base is tied to 0.
- The synchroniser, edge detect and FSM stay in int_controller.

Test Plan:
- Reset: release rst_n, write mask=8'h00, gie_set; pulse irq[3] -> pending[3]=1 after 3 clk, int_req=1 with int_vector=3 on the next clk; int_ack -> pending[3]=0, gie=0, in_service=1.
- Priority: raise irq[5] and irq[2] in the same cycle -> vector 2 first; after int_done, vector 5 follows. With INTC_ROUND_ROBIN_EN, after servicing 2 then 5 with 2 re-pending and 6 pending -> vector 6 before 2.
- Masking: mask=8'h10, irq[4] pulse -> pending[4]=1, int_req stays 0; mask=8'h00 -> int_req=1 with vector 4.
- Nesting block: in SERVICE pulse irq[1] -> pending[1]=1, int_req=0 until int_done; gie_set during SERVICE has no effect.
- Collision: new irq[3] edge in the ack cycle for vector 3 -> pending[3] remains 1, re-requested after int_done.
- Async reset asserted in REQ -> int_req, pending and gie drop to 0 without waiting for a clk edge; state returns to IDLE.
